// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg
// Shared definitions for the sequential shift-add multiplier.
//   state_t        : FSM state encoding (IDLE / RUN / FIN)
//   DEFAULT_WIDTH  : default operand width in bits
package seq_mult_pkg;

  localparam int DEFAULT_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_add.sv
// add_n
// Parametrised ripple-carry adder.
//   x, y : N-bit addends
//   cin  : carry in
//   sum  : N-bit sum
//   cout : carry out of the top bit
module add_n #(
  parameter int N = 6
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign sum[gi]     = x[gi] ^ y[gi] ^ carry[gi];
    assign carry[gi+1] = (x[gi] & y[gi]) | (x[gi] & carry[gi]) | (y[gi] & carry[gi]);
  end

  assign cout = carry[N];

endmodule

// File: rtl/seq_mult.sv
// seq_mult
// Sequential shift-add multiplier: one add/shift step per clock, WIDTH steps
// per product, with a one-cycle FIN state that pulses done.
//   clk       : clock, all state on rising edge
//   rst       : synchronous active-high reset
//   start     : begin a multiply with the current a/b (accepted when not busy)
//   a, b      : multiplicand / multiplier, WIDTH bits
//   is_signed : (only with SEQ_MULT_SIGNED_EN) treat a/b as two's complement
//   busy      : high while the multiply is running
//   done      : one-cycle pulse, p valid
//   p         : full 2*WIDTH-bit product, held until the next one completes
// Optional feature macro: SEQ_MULT_SIGNED_EN adds signed operation.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic                 is_signed,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t               state;
  logic [WIDTH-1:0]     mcand;   // latched multiplicand (magnitude when signed)
  logic [WIDTH-1:0]     hi;      // upper half of the running product
  logic [WIDTH-1:0]     lo;      // multiplier, shifted out as product bits shift in
  logic [CNT_W-1:0]     count;   // steps remaining in RUN
  logic [2*WIDTH-1:0]   p_reg;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 carry;
  logic [2*WIDTH-1:0]   prod_next;
  logic [2*WIDTH-1:0]   result;
  logic [WIDTH-1:0]     a_load;
  logic [WIDTH-1:0]     b_load;
  logic                 accept;

  assign accept = start && (state != RUN);

  // Only add the multiplicand when the current multiplier LSB is set.
  assign addend = lo[0] ? mcand : '0;

  // Partial sum is {carry, sum}: WIDTH+1 bits, so the carry is never dropped.
  add_n #(.N(WIDTH)) u_add (
    .x    (hi),
    .y    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  // Shift the (WIDTH+1)-bit partial sum and the multiplier right together.
  assign prod_next = {carry, sum, lo[WIDTH-1:1]};

`ifdef SEQ_MULT_SIGNED_EN
  logic neg;   // result must be negated (signed mode, operand signs differ)

  // Signed mode multiplies magnitudes; the most negative value's magnitude
  // still fits as an unsigned WIDTH-bit number.
  assign a_load = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_load = (is_signed && b[WIDTH-1]) ? -b : b;
  assign result = neg ? -prod_next : prod_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg <= 1'b0;
    end else if (accept) begin
      neg <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
    end
  end
`else
  assign a_load = a;
  assign b_load = b;
  assign result = prod_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      count <= '0;
      p_reg <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            state <= RUN;
            mcand <= a_load;
            lo    <= b_load;
            hi    <= '0;
            count <= CNT_W'(WIDTH);
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          hi    <= prod_next[2*WIDTH-1:WIDTH];
          lo    <= prod_next[WIDTH-1:0];
          count <= count - CNT_W'(1);
          // Last step: the product is complete on this edge.
          if (count == CNT_W'(1)) begin
            state <= FIN;
            p_reg <= result;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == FIN);
  assign p    = p_reg;

endmodule

// File: tb/tb_seq_mult.sv
module tb_seq_mult;

  localparam int W = 6;
`ifdef SEQ_MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           is_signed;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int n_cmp = 0;
  int n_bad = 0;

  seq_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef SEQ_MULT_SIGNED_EN
    .is_signed (is_signed),
`endif
    .busy      (busy),
    .done      (done),
    .p         (p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer product, operands sign-extended in signed mode.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input bit sg);
    longint xv = longint'(x);
    longint yv = longint'(y);
    if (sg && x[W-1]) xv = xv - (longint'(1) << W);
    if (sg && y[W-1]) yv = yv - (longint'(1) << W);
    return (2*W)'(xv * yv);
  endfunction

  // Samples then advances until done, bounded; counts busy cycles seen.
  task automatic wait_done(output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    while (!done && n < 40) begin
      if (busy) busy_n++;
      tick();
      n++;
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input bit sg);
    int n, bn;
    logic [2*W-1:0] exp;
    exp = ref_mul(av, bv, sg && SIGNED_EN);
    a = av; b = bv; is_signed = sg; start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    wait_done(n, bn);
    $display("op %s a=%0d b=%0d s=%0d p=%0d exp=%0d lat=%0d", tag, av, bv, sg, p, exp, n);
    check({tag, "_lat"}, n, W);
    check({tag, "_busy"}, bn, W);
    check({tag, "_p"}, p, exp);
    tick();
    check({tag, "_done_low"}, done, 0);
    check({tag, "_p_hold"}, p, exp);
  endtask

  initial begin
    int n, bn, cnt;
    logic [W-1:0] ra, rb;
    bit rs;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_p", p, 0);
    // Reset overrides start.
    start = 1'b1; a = 6'd7; b = 6'd7;
    tick();
    check("rst_over_start", busy, 0);
    start = 1'b0;
    rst = 1'b0;
    tick();

    do_op("max", 6'd63, 6'd63, 1'b0);
    check("max_val", p, 12'hF81);
    do_op("zero", 6'd0, 6'd0, 1'b0);

    // Back-to-back: new start during FIN.
    a = 6'd45; b = 6'd27; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, bn);
    check("b2b_p1", p, 1215);
    a = 6'd0; b = 6'd50; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_hold", p, 1215);
    wait_done(n, bn);
    $display("op b2b a=0 b=50 p=%0d gap=%0d", p, n + 1);
    check("b2b_gap", n + 1, 7);
    check("b2b_p2", p, 0);
    tick();

    // Start while busy is ignored.
    a = 6'd10; b = 6'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 6'd5; b = 6'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, bn);
    $display("op ignore a=10 b=3 p=%0d lat=%0d", p, n + 3);
    check("ign_lat", n + 3, W);
    check("ign_p", p, 30);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) cnt++;
    end
    check("ign_no_second", cnt, 0);
    check("ign_p_hold", p, 30);

    // Reset mid-run aborts.
    a = 6'd63; b = 6'd63; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_p", p, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) cnt++;
      tick();
    end
    $display("op abort done_pulses=%0d p=%0d", cnt, p);
    check("abort_no_done", cnt, 0);
    do_op("after_rst", 6'd2, 6'd3, 1'b0);

    if (SIGNED_EN) begin
      do_op("s_n32x31", 6'h20, 6'd31, 1'b1);
      check("s_n32x31_val", p, 12'hC20);
      do_op("s_n32xn32", 6'h20, 6'h20, 1'b1);
      check("s_n32xn32_val", p, 1024);
      do_op("u_32x31", 6'h20, 6'h1F, 1'b0);
      check("u_32x31_val", p, 992);
    end

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i == 0) ra = '0;
      if (i == 1) begin ra = '1; rb = '1; end
      rs = SIGNED_EN ? bit'($urandom_range(0, 1)) : 1'b0;
      do_op("rand", ra, rb, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
